// File: rtl/mem_access_stage_if.sv
// Handshaked data-memory bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: byte/half/word loads and stores over a handshaked bus,
// stalling the pipeline until ack or timeout, then presenting the extended load value.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 op_valid,
  input  logic                 mem_rd,
  input  logic                 mem_wr,
  input  logic [1:0]           mem_size,
  input  logic                 mem_sext,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  mem_access_stage_if.master   bus,
  output logic [31:0]          dmem_data,
  output logic                 stall,
  output logic                 addr_err,
  output logic                 bus_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             is_mem, mis, start;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;
  logic [1:0]       lat_a, lat_size;
  logic             lat_sext, lat_rd;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_val;

  assign mis      = ((mem_size == 2'd1) & addr[0]) | (mem_size[1] & (addr[1:0] != 2'b00));
  assign is_mem   = op_valid & (mem_rd | mem_wr);
  assign addr_err = is_mem & mis;
  assign start    = is_mem & ~mis;

  always_comb begin
    be_c    = '0;
    wdata_c = '0;
    case (mem_size)
      2'd0: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      2'd1: begin
        be_c    = 4'b0011 << addr[1:0];
        wdata_c = {2{wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = wdata;
      end
    endcase
  end

  // Lane selection uses the offset latched at issue, not the live address.
  always_comb begin
    byte_sel = bus.dmem_rdata[{lat_a, 3'b000} +: 8];
    half_sel = lat_a[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    case (lat_size)
      2'd0:    load_val = {{24{lat_sext & byte_sel[7]}}, byte_sel};
      2'd1:    load_val = {{16{lat_sext & half_sel[15]}}, half_sel};
      default: load_val = bus.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = start;
        if (start) state_nxt = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (bus.dmem_ack || cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_be    <= '0;
      bus.dmem_wdata <= '0;
      dmem_data      <= '0;
      bus_err        <= 1'b0;
      cnt            <= '0;
      lat_a          <= '0;
      lat_size       <= '0;
      lat_sext       <= 1'b0;
      lat_rd         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bus.dmem_req   <= 1'b1;
            bus.dmem_we    <= mem_wr;
            bus.dmem_addr  <= {addr[31:2], 2'b00};
            bus.dmem_be    <= be_c;
            bus.dmem_wdata <= wdata_c;
            cnt            <= '0;
            lat_a          <= addr[1:0];
            lat_size       <= mem_size;
            lat_sext       <= mem_sext;
            lat_rd         <= mem_rd;
          end
        end
        WAIT: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (bus.dmem_ack) begin
            bus.dmem_req <= 1'b0;
            bus_err      <= 1'b0;
            if (lat_rd) dmem_data <= load_val;
          end else if (cnt == CNT_LAST) begin
            bus.dmem_req <= 1'b0;
            bus_err      <= 1'b1;
            if (lat_rd) dmem_data <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    bus_err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised bench for mem_access_stage against a transaction-level model of the MEM stage.
module tb_mem_access_stage;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid, mem_rd, mem_wr, mem_sext;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata;
  logic [31:0] dmem_data;
  logic        stall, addr_err, bus_err;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_size(mem_size), .mem_sext(mem_sext), .addr(addr), .wdata(wdata),
    .bus(bus.master), .dmem_data(dmem_data), .stall(stall),
    .addr_err(addr_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic        e_req, e_we, e_stall, e_addr_err, e_bus_err;
  logic [31:0] e_addr, e_wdata, e_data;
  logic [3:0]  e_be;

  int          stall_len;
  logic        w_req, w_we, dn_bus_err;
  logic [31:0] w_addr, w_wdata, dn_data;
  logic [3:0]  w_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules: an access of n bytes is legal only at a multiple of n.
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit mis_f(input logic [1:0] sz, input logic [1:0] a);
    return (int'(a) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] be_f(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] b;
    for (int k = 0; k < 4; k++) b[k] = (k >= int'(a)) && (k < int'(a) + nbytes(sz));
    return b;
  endfunction

  function automatic logic [31:0] wd_f(input logic [1:0] sz, input logic [31:0] w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = w[8*(k % nbytes(sz)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ld_f(input logic [1:0] sz, input logic sx,
                                       input logic [1:0] a, input logic [31:0] rd);
    int n;
    logic [31:0] v;
    n = nbytes(sz);
    v = '0;
    for (int i = 0; i < n; i++) v |= ((rd >> (8*(int'(a) + i))) & 32'hFF) << (8*i);
    if (sx && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall",      {31'd0, stall},          {31'd0, e_stall});
      chk("addr_err",   {31'd0, addr_err},       {31'd0, e_addr_err});
      chk("bus_err",    {31'd0, bus_err},        {31'd0, e_bus_err});
      chk("dmem_data",  dmem_data,               e_data);
      chk("dmem_req",   {31'd0, bus.dmem_req},   {31'd0, e_req});
      chk("dmem_we",    {31'd0, bus.dmem_we},    {31'd0, e_we});
      chk("dmem_addr",  bus.dmem_addr,           e_addr);
      chk("dmem_be",    {28'd0, bus.dmem_be},    {28'd0, e_be});
      chk("dmem_wdata", bus.dmem_wdata,          e_wdata);
    end
  end

  task automatic set_in(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a, input logic [31:0] wd);
    op_valid = v; mem_rd = rd; mem_wr = wr; mem_size = sz; mem_sext = sx;
    addr = a; wdata = wd;
    e_addr_err = v && (rd || wr) && mis_f(sz, a[1:0]);
  endtask

  task automatic rand_in();
    int kind;
    kind = $urandom_range(0, 2);
    set_in(1'($urandom), kind == 1, kind == 2, 2'($urandom), 1'($urandom), $urandom, $urandom);
    bus.dmem_ack   = 1'($urandom);
    bus.dmem_rdata = $urandom;
  endtask

  task automatic tick();
    #1;
    if (stall) stall_len++;
    @(posedge clk);
    #1;
  endtask

  // One instruction through MEM: issue cycle, WAIT cycles, DONE cycle.
  task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input int delay,
                       input logic [31:0] rdat);
    bit done_now, timed;
    int w;
    stall_len = 0;
    set_in(1'b1, rd, wr, sz, sx, a, wd);
    bus.dmem_ack   = 1'($urandom);
    bus.dmem_rdata = $urandom;
    e_bus_err = 1'b0;
    if (!(rd || wr) || mis_f(sz, a[1:0])) begin
      e_stall = 1'b0; e_req = 1'b0;
      tick();
      return;
    end
    e_stall = 1'b1; e_req = 1'b0;
    tick();
    e_req = 1'b1; e_we = wr; e_addr = {a[31:2], 2'b00};
    e_be = be_f(sz, a[1:0]); e_wdata = wd_f(sz, wd);
    w_req = bus.dmem_req; w_we = bus.dmem_we; w_addr = bus.dmem_addr;
    w_be = bus.dmem_be; w_wdata = bus.dmem_wdata;
    timed = 1'b0;
    for (w = 1; w <= int'(TIMEOUT); w++) begin
      rand_in();
      bus.dmem_ack   = (w == delay);
      bus.dmem_rdata = (w == delay) ? rdat : $urandom;
      done_now = (w == delay) || (w == int'(TIMEOUT));
      timed    = (w != delay) && (w == int'(TIMEOUT));
      tick();
      if (done_now) break;
    end
    if (rd) e_data = timed ? 32'd0 : ld_f(sz, sx, a[1:0], rdat);
    e_req = 1'b0; e_stall = 1'b0; e_bus_err = timed;
    rand_in();
    #1;
    dn_bus_err = bus_err;
    dn_data    = dmem_data;
    tick();
    e_bus_err = 1'b0;
  endtask

  initial begin
    set_in(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    e_req = 0; e_we = 0; e_stall = 0; e_bus_err = 0;
    e_addr = '0; e_wdata = '0; e_data = '0; e_be = '0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Signed byte load at the top lane.
    do_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_1003, $urandom, 1, 32'h80FF_1234);
    chk("lb_addr", w_addr, 32'h0000_1000);
    chk("lb_be", {28'd0, w_be}, 32'h8);
    chk("lb_stall_len", stall_len, 2);
    chk("lb_data", dn_data, 32'hFFFF_FF80);

    // Zero-extended half load, ack on third WAIT cycle.
    do_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_2002, $urandom, 3, 32'h8001_0000);
    chk("lhu_data", dn_data, 32'h0000_8001);
    chk("lhu_stall_len", stall_len, 4);

    // Half store to the upper half-word; load result must be untouched.
    do_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0006, 32'hDEAD_BEEF, 5, $urandom);
    chk("sh_we", {31'd0, w_we}, 32'd1);
    chk("sh_be", {28'd0, w_be}, 32'hC);
    chk("sh_wdata", w_wdata, 32'hBEEF_BEEF);
    chk("sh_data_kept", dn_data, 32'h0000_8001);

    // Misaligned word load.
    set_in(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0001, 32'd0);
    #1;
    chk("mis_addr_err", {31'd0, addr_err}, 32'd1);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0001, 32'd0, 1, 32'd0);
    chk("mis_stall_len", stall_len, 0);

    // Timeout, then an immediate word load acked at once.
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'd0, 0, 32'd0);
    chk("to_stall_len", stall_len, 17);
    chk("to_bus_err", {31'd0, dn_bus_err}, 32'd1);
    chk("to_data", dn_data, 32'd0);
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0044, 32'd0, 1, 32'h1234_5678);
    chk("b2b_req", {31'd0, w_req}, 32'd1);
    chk("b2b_bus_err", {31'd0, dn_bus_err}, 32'd0);
    chk("b2b_data", dn_data, 32'h1234_5678);

    // Reset asserted mid-WAIT.
    set_in(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0);
    bus.dmem_ack = 1'b0;
    e_stall = 1'b1; e_req = 1'b0;
    tick();
    e_req = 1'b1; e_we = 1'b0; e_addr = 32'h0000_0100; e_be = 4'hF; e_wdata = 32'd0;
    tick();
    tick();
    chk_en = 1'b0;
    #2 rst = 1'b0;
    #1 chk("rst_req_async", {31'd0, bus.dmem_req}, 32'd0);
    set_in(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    e_req = 0; e_we = 0; e_stall = 0; e_bus_err = 0;
    e_addr = '0; e_wdata = '0; e_data = '0; e_be = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    tick();

    // Randomised traffic, including non-memory ops, misaligned ops and timeouts.
    for (int unsigned i = 0; i < 400; i++) begin
      int kind, dly;
      kind = $urandom_range(0, 4);
      dly  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, TIMEOUT + 3) : $urandom_range(1, 4);
      do_op(kind == 1 || kind == 2, kind == 3 || kind == 4, 2'($urandom), 1'($urandom),
            $urandom, $urandom, dly, $urandom);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
